// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: default geometry,
// a configuration check and the full-adder cell the carry slices are built from.
package pipelined_add_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    typedef struct packed {
        logic carry;
        logic sum;
    } fa_t;

    function automatic fa_t full_adder(input logic a, input logic b, input logic ci);
        fa_t r;
        r.sum   = a ^ b ^ ci;
        r.carry = (a & b) | (a & ci) | (b & ci);
        return r;
    endfunction

    // Geometry is legal when the carry chain splits into equal, non-empty slices.
    function automatic logic slicing_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_add_sub_add_slice.sv
// Combinational ripple-carry slice; also exposes the carry into its top bit
// so the final slice can flag signed overflow.
module add_slice
    import pipelined_add_sub_pkg::*;
#(
    parameter int unsigned SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cIn,
    output logic [SW-1:0] sum,
    output logic          cOut,
    output logic          carryMsbIn
);

    logic carry;
    logic carry_msb;
    fa_t  fa;

    always_comb begin
        sum       = '0;
        carry     = cIn;
        carry_msb = cIn;
        fa        = '0;
        for (int unsigned i = 0; i < SW; i++) begin
            carry_msb = carry;
            fa        = full_adder(a[i], b[i], carry);
            sum[i]    = fa.sum;
            carry     = fa.carry;
        end
        cOut       = carry;
        carryMsbIn = carry_msb;
    end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one carry slice per stage, operands
// skewed through the pipe, valid/ready handshake with whole-pipe stall.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cIn,
    input  logic             sub,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SW = WIDTH / STAGES;

    if (!slicing_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a non-zero multiple of STAGES");
    end

    logic advance;

    // Stage boundary buses: index k feeds stage k, index STAGES is the output.
    // ws carries a rotating mix of pending A slices and finished sum slices,
    // so the slice being worked on always sits in the low SW bits.
    logic [WIDTH-1:0] ws_s [STAGES+1];
    logic [WIDTH-1:0] b_s  [STAGES];
    logic [STAGES:0]  c_s;
    logic [STAGES:0]  vld_s;

    assign advance  = outReady | ~outValid;
    assign inReady  = advance;

    assign ws_s[0]  = in1;
    assign b_s[0]   = sub ? ~in2 : in2;
    assign c_s[0]   = sub | cIn;
    assign vld_s[0] = inValid;

    assign sum      = ws_s[STAGES];
    assign cOut     = c_s[STAGES];
    assign outValid = vld_s[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    slice_sum;
        logic             slice_cout;
        logic             slice_cmsb;
        logic [WIDTH-1:0] ws_d;
        logic [WIDTH-1:0] ws_q;
        logic             c_q;
        logic             vld_q;
        logic             load;

        add_slice #(.SW(SW)) u_slice (
            .a          (ws_s[k][SW-1:0]),
            .b          (b_s[k][SW-1:0]),
            .cIn        (c_s[k]),
            .sum        (slice_sum),
            .cOut       (slice_cout),
            .carryMsbIn (slice_cmsb)
        );

        if (STAGES > 1) begin : g_rot
            assign ws_d = {slice_sum, ws_s[k][WIDTH-1:SW]};
        end else begin : g_flat
            assign ws_d = slice_sum;
        end

        assign load = advance & vld_s[k];

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                vld_q <= 1'b0;
            end else if (advance) begin
                vld_q <= vld_s[k];
            end
        end

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                ws_q <= '0;
                c_q  <= 1'b0;
            end else if (load) begin
                ws_q <= ws_d;
                c_q  <= slice_cout;
            end
        end

        assign ws_s[k+1]  = ws_q;
        assign c_s[k+1]   = c_q;
        assign vld_s[k+1] = vld_q;

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] b_q;
            logic             unused_cmsb;

            assign unused_cmsb = slice_cmsb;

            // Rotate B' alongside ws so the next slice lands in the low bits.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    b_q <= '0;
                end else if (load) begin
                    b_q <= {b_s[k][SW-1:0], b_s[k][WIDTH-1:SW]};
                end
            end

            assign b_s[k+1] = b_q;
        end else begin : g_last
            logic             ov_q;
            logic             z_q;
            logic [WIDTH-1:0] unused_b;

            assign unused_b = b_s[k];

            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    ov_q <= 1'b0;
                    z_q  <= 1'b0;
                end else if (load) begin
                    ov_q <= slice_cmsb ^ slice_cout;
                    z_q  <= (ws_d == '0);
                end
            end

            assign overflow = ov_q;
            assign zero     = z_q;
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Randomised and directed bench for pipelined_add_sub at STAGES = 4, 1 and 32,
// scored against an arithmetic reference model with per-lane expectation queues.
module tb_pipelined_add_sub;

    localparam int unsigned W  = 32;
    localparam int          NL = 3;
    localparam int          ND = 7;

    localparam logic [W-1:0] DA [ND] = '{32'd5, 32'd3, 32'd5, 32'h7FFF_FFFF,
                                         32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    localparam logic [W-1:0] DB [ND] = '{32'd3, 32'd5, 32'd5, 32'd1,
                                         32'd0, 32'd1, 32'd1};
    localparam logic DS [ND] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic DC [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        res_t        res;
        int unsigned acc_cyc;
        bit          lat_chk;
    } exp_t;

    logic          clk;
    logic          rstN;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          sub;
    logic          cin;
    logic [NL-1:0] in_valid;
    logic [NL-1:0] in_ready;
    logic [NL-1:0] out_valid;
    logic [NL-1:0] out_ready;
    logic [NL-1:0] c_out;
    logic [NL-1:0] ovf;
    logic [NL-1:0] zero;
    logic [W-1:0]  sum_o [NL];

    int unsigned   n_checks;
    int unsigned   n_pass;
    int unsigned   cyc;
    int unsigned   rcv_cnt [NL];
    exp_t          exp_q [NL][$];
    logic [NL-1:0] acc_flag;
    logic [NL-1:0] rdy_s;
    bit            lat_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(W), .STAGES(4)) u_dut4 (
        .clk(clk), .rstN(rstN), .inValid(in_valid[0]), .inReady(in_ready[0]),
        .in1(in1), .in2(in2), .cIn(cin), .sub(sub),
        .outValid(out_valid[0]), .outReady(out_ready[0]), .sum(sum_o[0]),
        .cOut(c_out[0]), .overflow(ovf[0]), .zero(zero[0])
    );

    pipelined_add_sub #(.WIDTH(W), .STAGES(1)) u_dut1 (
        .clk(clk), .rstN(rstN), .inValid(in_valid[1]), .inReady(in_ready[1]),
        .in1(in1), .in2(in2), .cIn(cin), .sub(sub),
        .outValid(out_valid[1]), .outReady(out_ready[1]), .sum(sum_o[1]),
        .cOut(c_out[1]), .overflow(ovf[1]), .zero(zero[1])
    );

    pipelined_add_sub #(.WIDTH(W), .STAGES(32)) u_dut32 (
        .clk(clk), .rstN(rstN), .inValid(in_valid[2]), .inReady(in_ready[2]),
        .in1(in1), .in2(in2), .cIn(cin), .sub(sub),
        .outValid(out_valid[2]), .outReady(out_ready[2]), .sum(sum_o[2]),
        .cOut(c_out[2]), .overflow(ovf[2]), .zero(zero[2])
    );

    function automatic int unsigned stages_of(input int l);
        case (l)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    endtask

    // Reference: plain unsigned and signed arithmetic on widened operands.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic ci);
        res_t              r;
        logic [W:0]        u;
        logic signed [W:0] sa;
        logic signed [W:0] sb;
        logic signed [W:0] sr;
        sa = $signed({a[W-1], a});
        sb = $signed({b[W-1], b});
        if (s) begin
            u  = {1'b0, a} - {1'b0, b};
            sr = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            sr = sa + sb + $signed({{W{1'b0}}, ci});
        end
        r.sum  = u[W-1:0];
        r.cout = s ? (a >= b) : u[W];
        r.ovf  = (sr != $signed({r.sum[W-1], r.sum}));
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic res_t observed(input int l);
        return {sum_o[l], c_out[l], ovf[l], zero[l]};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return '0;
            default: return W'($urandom());
        endcase
    endfunction

    // One cycle: sample after negedge settles, score outputs, record accepts.
    task automatic tick();
        exp_t e;
        #1;
        acc_flag = '0;
        for (int l = 0; l < NL; l++) begin
            rdy_s[l] = in_ready[l];
            if (out_valid[l]) begin
                if (exp_q[l].size() == 0) begin
                    check($sformatf("spurious_out_l%0d", l), 64'(out_valid[l]), 64'(0));
                end else begin
                    e = exp_q[l][0];
                    check($sformatf("result_l%0d", l), 64'(observed(l)), 64'(e.res));
                    if (out_ready[l]) begin
                        exp_q[l].delete(0);
                        rcv_cnt[l]++;
                        if (e.lat_chk)
                            check($sformatf("latency_l%0d", l), 64'(cyc - e.acc_cyc),
                                  64'(stages_of(l)));
                    end
                end
            end
            if (in_valid[l] && in_ready[l]) begin
                e.res     = model(in1, in2, sub, cin);
                e.acc_cyc = cyc;
                e.lat_chk = lat_mode;
                exp_q[l].push_back(e);
                acc_flag[l] = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic issue(input int l, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci);
        in1 = a; in2 = b; sub = s; cin = ci;
        in_valid[l] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc_flag[l]) break;
        end
        check($sformatf("issue_accept_l%0d", l), 64'(acc_flag[l]), 64'(1));
        in_valid[l] = 1'b0;
    endtask

    task automatic drain(input int l);
        out_ready[l] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (exp_q[l].size() == 0) break;
            tick();
        end
        check($sformatf("drain_l%0d", l), 64'(exp_q[l].size()), 64'(0));
    endtask

    task automatic run_lane(input int l);
        int unsigned base;
        int          i;
        int          stall;
        bit          stalled;
        int          seen;

        // Directed corner operations, one at a time with latency checking.
        lat_mode = 1'b1;
        for (int d = 0; d < ND; d++) begin
            issue(l, DA[d], DB[d], DS[d], DC[d]);
            drain(l);
        end
        lat_mode = 1'b0;

        // Eight-op stream with a 3-cycle consumer stall after the second result.
        base = rcv_cnt[l]; i = 0; stall = 0; stalled = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (i >= 8 && exp_q[l].size() == 0) break;
            if (!stalled && (rcv_cnt[l] - base) >= 2) begin
                stall = 3;
                stalled = 1'b1;
            end
            out_ready[l] = (stall == 0);
            in_valid[l]  = (i < 8);
            in1 = W'(i); in2 = W'(i); sub = 1'b0; cin = 1'b0;
            tick();
            if (stall > 0) begin
                check($sformatf("stall_in_ready_l%0d", l), 64'(rdy_s[l]), 64'(0));
                stall--;
            end
            if (acc_flag[l]) i++;
        end
        in_valid[l]  = 1'b0;
        out_ready[l] = 1'b1;
        check($sformatf("stream_count_l%0d", l), 64'(rcv_cnt[l] - base), 64'(8));

        // Random traffic with random back-pressure.
        for (int k = 0; k < 150; k++) begin
            in_valid[l]  = 1'($urandom_range(0, 1));
            out_ready[l] = ($urandom_range(0, 3) != 0);
            in1 = rnd_operand(); in2 = rnd_operand();
            sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid[l] = 1'b0;
        drain(l);

        // Reset with work in flight and a result held at the output.
        out_ready[l] = 1'b1;
        for (int j = 0; j < 3; j++)
            issue(l, rnd_operand() | 32'h1, rnd_operand(), 1'b0, 1'b1);
        out_ready[l] = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid[l]) break;
            tick();
        end
        check($sformatf("pre_reset_valid_l%0d", l), 64'(out_valid[l]), 64'(1));
        #2;
        rstN = 1'b0;
        for (int q = 0; q < NL; q++) exp_q[q].delete();
        #1;
        check($sformatf("reset_clears_l%0d", l), 64'({out_valid[l], observed(l)}), 64'(0));
        @(negedge clk);
        rstN = 1'b1;
        out_ready[l] = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            seen += int'(out_valid[l]);
            tick();
        end
        check($sformatf("no_ghost_after_reset_l%0d", l), 64'(seen), 64'(0));
        lat_mode = 1'b1;
        issue(l, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        drain(l);
        lat_mode = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; lat_mode = 1'b0;
        rcv_cnt  = '{default: 0};
        rstN = 1'b0; in_valid = '0; out_ready = '1; acc_flag = '0; rdy_s = '0;
        in1 = '0; in2 = '0; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        #1;
        for (int l = 0; l < NL; l++) begin
            check($sformatf("reset_state_l%0d", l), 64'({out_valid[l], observed(l)}), 64'(0));
            check($sformatf("reset_in_ready_l%0d", l), 64'(in_ready[l]), 64'(1));
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        for (int l = 0; l < NL; l++) run_lane(l);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
